mem_port_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single unified instruction/data memory port.
- Requester 0 is the multicycle core's memory interface. Requester 1 is a secondary master, such as a program loader or debug port.
- Grants one transaction at a time, drives the memory port, counts the fixed memory read latency and returns registered read data or a write acknowledge to the winner.
- Sits between the masters and the memory model in the top level.

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-master arbiter and sequencer for the unified memory port.
// Define ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module mem_port_arbiter #(
    parameter int LAT = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_wd,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_wd,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rd
);

    if (LAT < 1 || LAT > 15) begin : g_lat_chk
        $error("mem_port_arbiter: LAT=%0d outside 1..15", LAT);
    end

    localparam logic [3:0] LAT_C = 4'(LAT);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          win_q, win_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          pick1;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        pick1 = m1_req && !m0_req;
    end
`else
    logic last_q, last_d;

    // On a tie the requester not granted last time wins.
    always_comb begin
        pick1 = m1_req && (!m0_req || !last_q);
    end
`endif

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        we_d     = we_q;
        adr_d    = adr_q;
        wd_d     = wd_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifndef ARB_FIXED_PRIO_EN
        last_d   = last_q;
`endif
        unique case (state_q)
            ARB, RESP: begin
                if (m0_req || m1_req) begin
                    state_d = ISSUE;
                    win_d   = pick1;
                    we_d    = pick1 ? m1_we  : m0_we;
                    adr_d   = pick1 ? m1_adr : m0_adr;
                    wd_d    = pick1 ? m1_wd  : m0_wd;
`ifndef ARB_FIXED_PRIO_EN
                    last_d  = pick1;
`endif
                end else begin
                    state_d = ARB;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = RESP;
                    if (win_q) begin
                        rdata1_d = '0;
                    end else begin
                        rdata0_d = '0;
                    end
                end else begin
                    state_d = WAIT;
                    cnt_d   = 4'd1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAT_C) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                    if (win_q) begin
                        rdata1_d = mem_rd;
                    end else begin
                        rdata0_d = mem_rd;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            wd_q     <= '0;
            cnt_q    <= 4'd0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            wd_q     <= wd_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Strobes and grant live only in ISSUE; the port idles at zero otherwise.
    assign m0_gnt    = (state_q == ISSUE) && !win_q;
    assign m1_gnt    = (state_q == ISSUE) && win_q;
    assign mem_re    = (state_q == ISSUE) && !we_q;
    assign mem_we    = (state_q == ISSUE) && we_q;
    assign mem_adr   = (state_q == ISSUE) ? adr_q : '0;
    assign mem_wd    = (state_q == ISSUE) ? wd_q : '0;
    assign m0_rvalid = (state_q == RESP) && !win_q;
    assign m1_rvalid = (state_q == RESP) && win_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: three arbiters (LAT 2, 1, 15) share one stimulus stream.
// A cycle-timeline transaction model predicts every output of every instance.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
    localparam logic [1:0] RR_ALT = 2'b01;
`else
    localparam bit FIXED = 1'b0;
    localparam logic [1:0] RR_ALT = 2'b10;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_adr, m1_adr;
    logic [DW-1:0] m0_wd, m1_wd;
    logic [2:0]    m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, mem_re;
    logic [DW-1:0] m0_rdata [3];
    logic [DW-1:0] m1_rdata [3];
    logic [DW-1:0] mem_wd [3];
    logic [DW-1:0] mem_rd [3];
    logic [AW-1:0] mem_adr [3];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int L = (k == 0) ? 2 : ((k == 1) ? 1 : 15);
        mem_port_arbiter #(.LAT(L), .AW(AW), .DW(DW)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .m0_req    (m0_req),
            .m0_we     (m0_we),
            .m0_adr    (m0_adr),
            .m0_wd     (m0_wd),
            .m0_gnt    (m0_gnt[k]),
            .m0_rvalid (m0_rvalid[k]),
            .m0_rdata  (m0_rdata[k]),
            .m1_req    (m1_req),
            .m1_we     (m1_we),
            .m1_adr    (m1_adr),
            .m1_wd     (m1_wd),
            .m1_gnt    (m1_gnt[k]),
            .m1_rvalid (m1_rvalid[k]),
            .m1_rdata  (m1_rdata[k]),
            .mem_adr   (mem_adr[k]),
            .mem_wd    (mem_wd[k]),
            .mem_we    (mem_we[k]),
            .mem_re    (mem_re[k]),
            .mem_rd    (mem_rd[k])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        if (a == 32'h48) return 32'hCAFEF00D;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    bit armed = 1'b0;
    bit rst_prev = 1'b0;

    int t_rst = -1000, t_rd = -1000, t_wr = -1000, t_rr = -1000;
    int t_mr = -1000, t_mr2 = -1000, t_dn = -1000, t_bw = -1000;

    // transaction model: one pending transaction per instance on a cycle timeline
    int          nxt [3]   = '{-1, -1, -1};
    int          iss_c [3] = '{-1, -1, -1};
    int          rsp_c [3] = '{-1, -1, -1};
    int          due [3]   = '{-1, -1, -1};
    logic [31:0] dval [3];
    bit          w_id [3];
    bit          w_we [3];
    bit          last [3];
    logic [31:0] w_adr [3];
    logic [31:0] w_wd [3];
    logic [31:0] x_rd0 [3];
    logic [31:0] x_rd1 [3];

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d cyc %0d: got %h, want %h",
                     nm, k, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : p_chk
        bit iss, rsp, w;
        for (int k = 0; k < 3; k++) begin
            if (mem_re[k] === 1'b1) begin
                due[k]  = cyc + lat_of(k);
                dval[k] = memval(mem_adr[k]);
            end
            mem_rd[k] = (cyc == due[k]) ? dval[k] : (32'hBAD00000 ^ 32'(cyc));

            if (armed) begin
                iss = (cyc == iss_c[k]);
                rsp = (cyc == rsp_c[k]);
                if (rsp) begin
                    if (w_id[k]) x_rd1[k] = w_we[k] ? 32'h0 : memval(w_adr[k]);
                    else         x_rd0[k] = w_we[k] ? 32'h0 : memval(w_adr[k]);
                end
                chk("m0_gnt", k, 32'(m0_gnt[k]), 32'(iss && !w_id[k]));
                chk("m1_gnt", k, 32'(m1_gnt[k]), 32'(iss && w_id[k]));
                chk("mem_re", k, 32'(mem_re[k]), 32'(iss && !w_we[k]));
                chk("mem_we", k, 32'(mem_we[k]), 32'(iss && w_we[k]));
                chk("m0_rvalid", k, 32'(m0_rvalid[k]), 32'(rsp && !w_id[k]));
                chk("m1_rvalid", k, 32'(m1_rvalid[k]), 32'(rsp && w_id[k]));
                chk("m0_rdata", k, m0_rdata[k], x_rd0[k]);
                chk("m1_rdata", k, m1_rdata[k], x_rd1[k]);
                if (iss || rst_prev) begin
                    chk("mem_adr", k, mem_adr[k], iss ? w_adr[k] : 32'h0);
                    chk("mem_wd", k, mem_wd[k], iss ? w_wd[k] : 32'h0);
                end
            end

            if (reset === 1'b1) begin
                nxt[k]   = cyc + 1;
                iss_c[k] = -1;
                rsp_c[k] = -1;
                last[k]  = 1'b1;
                x_rd0[k] = 32'h0;
                x_rd1[k] = 32'h0;
            end else if (armed && cyc == nxt[k]) begin
                if (m0_req || m1_req) begin
                    if (m0_req && m1_req) w = FIXED ? 1'b0 : !last[k];
                    else                  w = m1_req;
                    w_id[k]  = w;
                    w_we[k]  = w ? m1_we : m0_we;
                    w_adr[k] = w ? m1_adr : m0_adr;
                    w_wd[k]  = w ? m1_wd : m0_wd;
                    last[k]  = w;
                    iss_c[k] = cyc + 1;
                    rsp_c[k] = cyc + 2 + (w_we[k] ? 0 : lat_of(k));
                    nxt[k]   = rsp_c[k];
                end else begin
                    nxt[k] = cyc + 1;
                end
            end
        end

        if (cyc == t_rst) begin
            chk("rst_ctl", 0, 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_re, mem_we}), 32'h0);
            chk("rst_data", 0, m0_rdata[0] | m1_rdata[0] | mem_adr[0] | mem_wd[0], 32'h0);
        end
        if (cyc == t_rd + 1) begin
            chk("rd_gnt", 0, 32'({m0_gnt[0], mem_re[0], mem_we[0]}), 32'b110);
            chk("rd_adr", 0, mem_adr[0], 32'h40);
        end
        if (cyc == t_rd + 3) chk("rd_lat1", 1, {m0_rvalid[1], m0_rdata[1][30:0]}, 32'hDEADBEEF | 32'h80000000);
        if (cyc == t_rd + 3) chk("rd_lat1_data", 1, m0_rdata[1], 32'hDEADBEEF);
        if (cyc == t_rd + 4) begin
            chk("rd_rvalid", 0, 32'(m0_rvalid[0]), 32'h1);
            chk("rd_data", 0, m0_rdata[0], 32'hDEADBEEF);
        end
        if (cyc == t_rd + 16) chk("rd_lat15_early", 2, 32'(m0_rvalid[2]), 32'h0);
        if (cyc == t_rd + 17) begin
            chk("rd_lat15_rvalid", 2, 32'(m0_rvalid[2]), 32'h1);
            chk("rd_lat15_data", 2, m0_rdata[2], 32'hDEADBEEF);
        end
        if (cyc == t_wr + 1) begin
            chk("wr_strobe", 0, 32'({m1_gnt[0], mem_we[0], mem_re[0]}), 32'b110);
            chk("wr_adr", 0, mem_adr[0], 32'h80);
            chk("wr_wd", 0, mem_wd[0], 32'h12345678);
        end
        if (cyc == t_wr + 2) begin
            chk("wr_ack", 0, 32'(m1_rvalid[0]), 32'h1);
            chk("wr_rdata", 0, m1_rdata[0], 32'h0);
        end
        if (cyc == t_rr + 1 || cyc == t_rr + 9)
            chk("rr_gnt", 0, 32'({m1_gnt[0], m0_gnt[0]}), 32'b01);
        if (cyc == t_rr + 5 || cyc == t_rr + 13)
            chk("rr_gnt", 0, 32'({m1_gnt[0], m0_gnt[0]}), 32'(RR_ALT));
        if (cyc == t_rr + 17)
            chk("rr_m1_after_drop", 0, 32'({m1_gnt[0], m0_gnt[0]}), 32'b10);
        if (cyc == t_mr + 3) begin
            chk("mr_out", 0, 32'({m0_rvalid[0], m0_gnt[0], mem_re[0], mem_we[0]}), 32'h0);
            chk("mr_rdata", 0, m0_rdata[0], 32'h0);
        end
        if (cyc == t_mr + 4) chk("mr_no_rvalid", 0, 32'(m0_rvalid[0]), 32'h0);
        if (cyc == t_mr2 + 4) begin
            chk("mr_next_rvalid", 0, 32'(m0_rvalid[0]), 32'h1);
            chk("mr_next_data", 0, m0_rdata[0], 32'hCAFEF00D);
        end
        if (cyc == t_dn + 5) chk("drop_no_gnt", 0, 32'({m1_gnt[0], m0_gnt[0]}), 32'h0);
        if (cyc == t_bw + 2) chk("bw_ack", 0, 32'({m0_gnt[0], m0_rvalid[0]}), 32'b01);
        if (cyc == t_bw + 3) begin
            chk("bw_gnt2", 0, 32'(m0_gnt[0]), 32'h1);
            chk("bw_wd2", 0, mem_wd[0], 32'h2222);
        end

        rst_prev = (reset === 1'b1);
        if (reset === 1'b1) armed = 1'b1;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_wd = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_wd = '0;
        idle(3);
        reset = 1'b0;
        t_rst = cyc;
        tick();

        // single read, seen by all three latencies
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h40; m0_wd = 32'h0;
        t_rd = cyc;
        tick();
        m0_req = 1'b0;
        idle(20);

        // single write from requester 1
        m1_req = 1'b1; m1_we = 1'b1; m1_adr = 32'h80; m1_wd = 32'h12345678;
        t_wr = cyc;
        tick();
        m1_req = 1'b0;
        idle(20);

        // contention: both hold reads
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h100;
        m1_req = 1'b1; m1_we = 1'b0; m1_adr = 32'h200;
        t_rr = cyc;
        idle(16);
        m0_req = 1'b0;
        tick();
        m1_req = 1'b0;
        idle(25);

        // reset during the wait phase of a read
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h44;
        t_mr = cyc;
        tick();
        m0_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        m0_req = 1'b1; m0_adr = 32'h48;
        t_mr2 = cyc;
        tick();
        m0_req = 1'b0;
        idle(20);

        // m1 request raised and withdrawn while m0 is in flight
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h60;
        t_dn = cyc;
        tick();
        m0_req = 1'b0;
        tick();
        m1_req = 1'b1; m1_we = 1'b0; m1_adr = 32'h64;
        tick();
        m1_req = 1'b0;
        idle(20);

        // back-to-back writes from m0 with changing payload
        t_bw = cyc;
        for (int i = 0; i < 8; i++) begin
            m0_req = 1'b1; m0_we = 1'b1;
            m0_adr = 32'h300 + 32'(i * 4);
            m0_wd = 32'(i) * 32'h1111;
            tick();
        end
        m0_req = 1'b0; m0_we = 1'b0;
        idle(25);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
